// File: rtl/manchester_word_encoder.sv
// Manchester word encoder: serialises handshaked words as bi-phase
// half-bit symbols on DIV8_CLK, with optional preamble and chaining.
// Ports: DIV8_CLK, globalReset (async, active-high), data_in,
//   data_valid, polarity -> data_ready, out, busy, word_done.
// Option macro: MANCHESTER_PARITY_EN appends an even-parity bit.
module manchester_word_encoder #(
    parameter int   DATA_W       = 8,
    parameter int   PREAMBLE_LEN = 2,
    parameter int   MSB_FIRST    = 1,
    parameter logic IDLE_LEVEL   = 1'b0
) (
    input  logic              DIV8_CLK,
    input  logic              globalReset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic              polarity,
    output logic              data_ready,
    output logic              out,
    output logic              busy,
    output logic              word_done
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam int PW = (PREAMBLE_LEN > 0) ?
                        $clog2(PREAMBLE_LEN + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
`ifdef MANCHESTER_PARITY_EN
    localparam logic [1:0] S_PAR  = 2'd3;
`endif

    logic [1:0]        r_state;
    logic              r_phase;
    logic [DATA_W-1:0] r_shift;
    logic              r_pol;
    logic [CW-1:0]     r_bitcnt;
    logic [PW-1:0]     r_precnt;
    logic              r_out;
    logic              r_rdy_en;

    logic [1:0]        w_state_nxt;
    logic              w_phase_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_pol_nxt;
    logic [CW-1:0]     w_bitcnt_nxt;
    logic [PW-1:0]     w_precnt_nxt;
    logic              w_out_nxt;
    logic              w_bit_nxt;
    logic              w_xfer;
    logic              w_bit_last;
    logic              w_pre_last;
    logic              w_last;

`ifdef MANCHESTER_PARITY_EN
    logic              r_par;
    logic              w_par_nxt;
`endif

    assign w_xfer     = data_valid & data_ready;
    assign w_bit_last = (r_bitcnt == CW'(DATA_W - 1));
    assign w_pre_last = (int'(r_precnt) == PREAMBLE_LEN - 1);

    // State register
    always_ff @(posedge DIV8_CLK or posedge globalReset) begin
        if (globalReset) begin
            r_state  <= S_IDLE;
            r_phase  <= 1'b0;
            r_shift  <= '0;
            r_pol    <= 1'b0;
            r_bitcnt <= '0;
            r_precnt <= '0;
            r_out    <= IDLE_LEVEL;
            r_rdy_en <= 1'b0;
`ifdef MANCHESTER_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_shift  <= w_shift_nxt;
            r_pol    <= w_pol_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_precnt <= w_precnt_nxt;
            r_out    <= w_out_nxt;
            r_rdy_en <= 1'b1;
`ifdef MANCHESTER_PARITY_EN
            r_par    <= w_par_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = ~r_phase;
        w_shift_nxt  = r_shift;
        w_pol_nxt    = r_pol;
        w_bitcnt_nxt = r_bitcnt;
        w_precnt_nxt = r_precnt;
`ifdef MANCHESTER_PARITY_EN
        w_par_nxt    = r_par;
`endif
        // end_word: either chain into S_DATA or drop to idle
        case (r_state)
            S_IDLE: begin
                w_phase_nxt = 1'b0;
                if (w_xfer) begin
                    w_state_nxt  = (PREAMBLE_LEN > 0) ? S_PRE : S_DATA;
                    w_shift_nxt  = data_in;
                    w_pol_nxt    = polarity;
                    w_bitcnt_nxt = '0;
                    w_precnt_nxt = '0;
`ifdef MANCHESTER_PARITY_EN
                    w_par_nxt    = ^data_in;
`endif
                end
            end
            S_PRE: begin
                if (r_phase) begin
                    w_precnt_nxt = r_precnt + PW'(1);
                    if (w_pre_last) w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (r_phase) begin
                    if (w_bit_last) begin
`ifdef MANCHESTER_PARITY_EN
                        w_state_nxt = S_PAR;
`else
                        w_state_nxt = S_IDLE;
                        if (w_xfer) begin
                            w_state_nxt  = S_DATA;
                            w_shift_nxt  = data_in;
                            w_pol_nxt    = polarity;
                            w_bitcnt_nxt = '0;
                            w_precnt_nxt = '0;
                        end
`endif
                    end else begin
                        w_shift_nxt = (MSB_FIRST != 0) ?
                                      (r_shift << 1) : (r_shift >> 1);
                        if (r_bitcnt != CW'(DATA_W))
                            w_bitcnt_nxt = r_bitcnt + CW'(1);
                    end
                end
            end
`ifdef MANCHESTER_PARITY_EN
            S_PAR: begin
                if (r_phase) begin
                    w_state_nxt = S_IDLE;
                    if (w_xfer) begin
                        w_state_nxt  = S_DATA;
                        w_shift_nxt  = data_in;
                        w_pol_nxt    = polarity;
                        w_bitcnt_nxt = '0;
                        w_precnt_nxt = '0;
                        w_par_nxt    = ^data_in;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_phase_nxt = 1'b0;
            end
        endcase
    end

    // Outputs; the line value is precomputed from the next state
    always_comb begin
`ifdef MANCHESTER_PARITY_EN
        w_last = (r_state == S_PAR) & r_phase;
`else
        w_last = (r_state == S_DATA) & r_phase & w_bit_last;
`endif
        data_ready = r_rdy_en & ((r_state == S_IDLE) | w_last);
        word_done  = w_last;
        busy       = (r_state != S_IDLE);
        out        = r_out;

        w_bit_nxt = 1'b0;
        case (w_state_nxt)
            S_PRE:   w_bit_nxt = ~w_precnt_nxt[0];
            S_DATA:  w_bit_nxt = (MSB_FIRST != 0) ?
                                 w_shift_nxt[DATA_W-1] : w_shift_nxt[0];
`ifdef MANCHESTER_PARITY_EN
            S_PAR:   w_bit_nxt = w_par_nxt;
`endif
            default: w_bit_nxt = 1'b0;
        endcase

        if (w_state_nxt == S_IDLE)
            w_out_nxt = IDLE_LEVEL;
        else
            w_out_nxt = w_bit_nxt ^ w_pol_nxt ^ w_phase_nxt;
    end

endmodule
